// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters channels A/B, decodes the Gray
// sequence into Step/Direction pulses and flags two-bit jumps as StepError.
`timescale 1ns / 1ps

module quadrature_step_decoder #(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned COUNT_MODE    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     ResetN,
    input  logic                     Enable,
    input  logic                     ChannelA,
    input  logic                     ChannelB,
    output logic                     Step,
    output logic                     Direction,
    output logic                     StepError,
    output logic [ERR_CNT_WIDTH-1:0] ErrorCount,
    output logic [1:0]               FilteredAB,
    output logic                     Ready
);

    localparam int unsigned FiltW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int unsigned InitW = $clog2(FILTER_CYCLES + 3);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);
    localparam logic [InitW-1:0] InitLast = InitW'(FILTER_CYCLES + 2);

    typedef enum logic {StInit, StRun} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               sync1_q, sync2_q;
    logic [InitW-1:0]         init_cnt_q, init_cnt_d;
    logic [FiltW-1:0]         filt_cnt_q [2];
    logic [FiltW-1:0]         filt_cnt_d [2];
    logic [1:0]               filt_q, filt_d;
    logic [1:0]               prev_q, prev_d;
    logic                     step_d, dir_d, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_d;
    logic [1:0]               fwd_next;
    logic                     changed, both, counted;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            sync1_q       <= 2'b00;
            sync2_q       <= 2'b00;
            state_q       <= StInit;
            init_cnt_q    <= '0;
            filt_cnt_q[0] <= '0;
            filt_cnt_q[1] <= '0;
            filt_q        <= 2'b00;
            prev_q        <= 2'b00;
            Step          <= 1'b0;
            Direction     <= 1'b1;
            StepError     <= 1'b0;
            ErrorCount    <= '0;
        end else begin
            sync1_q       <= {ChannelA, ChannelB};
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            filt_cnt_q[0] <= filt_cnt_d[0];
            filt_cnt_q[1] <= filt_cnt_d[1];
            filt_q        <= filt_d;
            prev_q        <= prev_d;
            Step          <= step_d;
            Direction     <= dir_d;
            StepError     <= err_d;
            ErrorCount    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        prev_d     = filt_q;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q == InitLast) begin
                    filt_d  = sync2_q;
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
                // Seed the decoder with the captured level so capture itself is not a transition.
                prev_d = filt_d;
            end
            StRun: begin
                for (int i = 0; i < 2; i++) begin
                    if (sync2_q[i] == filt_q[i]) begin
                        filt_cnt_d[i] = '0;
                    end else if (filt_cnt_q[i] == FiltLast) begin
                        filt_d[i]     = sync2_q[i];
                        filt_cnt_d[i] = '0;
                    end else begin
                        filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        fwd_next = 2'b00;
        case (prev_q)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
        changed = (filt_q != prev_q);
        both    = &(filt_q ^ prev_q);
        if (COUNT_MODE == 1) begin
            counted = (filt_q == 2'b00);
        end else if (COUNT_MODE == 2) begin
            counted = (filt_q == 2'b00) || (filt_q == 2'b11);
        end else begin
            counted = 1'b1;
        end

        step_d    = 1'b0;
        dir_d     = Direction;
        err_d     = 1'b0;
        err_cnt_d = ErrorCount;
        // prev_q keeps tracking while disabled, so re-enabling never replays old transitions.
        if (state_q == StRun && Enable && changed) begin
            if (both) begin
                err_d = 1'b1;
                if (ErrorCount != '1) begin
                    err_cnt_d = ErrorCount + 1'b1;
                end
            end else if (counted) begin
                step_d = 1'b1;
                dir_d  = (filt_q == fwd_next);
            end
        end
    end

    assign FilteredAB = filt_q;
    assign Ready      = (state_q == StRun);

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Bench for quadrature_step_decoder: three instances (COUNT_MODE 4, 2, 1) share the same
// encoder stimulus and are checked against a position-based model of the encoder.
`timescale 1ns / 1ps

module tb_quadrature_step_decoder;

    localparam int FC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic ch_a = 1'b0;
    logic ch_b = 1'b0;

    logic [2:0] step, dir, serr, rdy;
    logic [7:0] ecnt [3];
    logic [1:0] fab [3];

    int n_checks = 0;
    int n_fail = 0;

    int step_cnt [3] = '{0, 0, 0};
    int up_cnt   [3] = '{0, 0, 0};
    int dn_cnt   [3] = '{0, 0, 0};
    int err_seen [3] = '{0, 0, 0};
    int bad_m1 = 0;

    always #5 clk = ~clk;

    quadrature_step_decoder #(.FILTER_CYCLES(FC), .COUNT_MODE(4), .ERR_CNT_WIDTH(8)) u_m4 (
        .Clk(clk), .ResetN(rst_n), .Enable(en), .ChannelA(ch_a), .ChannelB(ch_b),
        .Step(step[0]), .Direction(dir[0]), .StepError(serr[0]), .ErrorCount(ecnt[0]),
        .FilteredAB(fab[0]), .Ready(rdy[0])
    );
    quadrature_step_decoder #(.FILTER_CYCLES(FC), .COUNT_MODE(2), .ERR_CNT_WIDTH(8)) u_m2 (
        .Clk(clk), .ResetN(rst_n), .Enable(en), .ChannelA(ch_a), .ChannelB(ch_b),
        .Step(step[1]), .Direction(dir[1]), .StepError(serr[1]), .ErrorCount(ecnt[1]),
        .FilteredAB(fab[1]), .Ready(rdy[1])
    );
    quadrature_step_decoder #(.FILTER_CYCLES(FC), .COUNT_MODE(1), .ERR_CNT_WIDTH(8)) u_m1 (
        .Clk(clk), .ResetN(rst_n), .Enable(en), .ChannelA(ch_a), .ChannelB(ch_b),
        .Step(step[2]), .Direction(dir[2]), .StepError(serr[2]), .ErrorCount(ecnt[2]),
        .FilteredAB(fab[2]), .Ready(rdy[2])
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (step[m] === 1'b1) begin
                step_cnt[m] <= step_cnt[m] + 1;
                if (dir[m] === 1'b1) up_cnt[m] <= up_cnt[m] + 1;
                else dn_cnt[m] <= dn_cnt[m] + 1;
            end
            if (serr[m] === 1'b1) err_seen[m] <= err_seen[m] + 1;
        end
        if (step[2] === 1'b1 && fab[2] !== 2'b00) bad_m1 <= bad_m1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic a, input logic b);
        rst_n = 1'b0;
        ch_a = a;
        ch_b = b;
        tick(2);
        rst_n = 1'b1;
        tick(FC + 3);
    endtask

    task automatic drive(input logic [1:0] ab, input int hold);
        ch_a = ab[1];
        ch_b = ab[0];
        tick(hold);
    endtask

    task automatic test_reset;
        int s_step [3];
        int s_err [3];
        en = 1'b1;
        rst_n = 1'b0;
        ch_a = 1'b1;
        ch_b = 1'b1;
        tick(2);
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (rdy[m] !== 1'b0 || fab[m] !== 2'b00 || step[m] !== 1'b0 || serr[m] !== 1'b0 ||
                dir[m] !== 1'b1 || ecnt[m] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: rdy=%b fab=%b step=%b err=%b dir=%b ecnt=%0d, required 0 00 0 0 1 0",
                         m, rdy[m], fab[m], step[m], serr[m], dir[m], ecnt[m]);
            end
        end
        s_step = step_cnt;
        s_err = err_seen;
        rst_n = 1'b1;
        tick(FC + 2);
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_early: got %b, required 0", rdy[0]);
        end
        tick(1);
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_time: got %b, required 1", rdy[0]);
        end
        n_checks++;
        if (fab[0] !== 2'b11) begin
            n_fail++;
            $display("FAIL init_capture: got %b, required 11", fab[0]);
        end
        tick(10);
        n_checks++;
        if (step_cnt[0] - s_step[0] != 0 || err_seen[0] - s_err[0] != 0) begin
            n_fail++;
            $display("FAIL init_quiet: steps %0d errors %0d, required 0 0",
                     step_cnt[0] - s_step[0], err_seen[0] - s_err[0]);
        end
    endtask

    task automatic test_forward;
        logic [1:0] seq [4];
        int s_step [3];
        int s_up;
        int first, nst;
        logic d7;
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        do_reset(1'b0, 1'b0);
        s_step = step_cnt;
        s_up = up_cnt[0];
        for (int l = 0; l < 4; l++) begin
            ch_a = seq[l][1];
            ch_b = seq[l][0];
            first = 0;
            nst = 0;
            d7 = 1'bx;
            for (int i = 1; i <= 10; i++) begin
                tick(1);
                if (step[0] === 1'b1) begin
                    nst++;
                    if (first == 0) first = i;
                end
                if (i == FC + 3) d7 = dir[0];
            end
            n_checks++;
            if (first != FC + 3 || nst != 1) begin
                n_fail++;
                $display("FAIL fwd_latency level %b: step at edge k+%0d count %0d, required k+%0d count 1",
                         seq[l], first - 1, nst, FC + 2);
            end
            n_checks++;
            if (d7 !== 1'b1) begin
                n_fail++;
                $display("FAIL fwd_dir level %b: got %b, required 1", seq[l], d7);
            end
            n_checks++;
            if (fab[0] !== seq[l]) begin
                n_fail++;
                $display("FAIL fwd_filtered: got %b, required %b", fab[0], seq[l]);
            end
        end
        n_checks++;
        if (step_cnt[0] - s_step[0] != 4 || up_cnt[0] - s_up != 4) begin
            n_fail++;
            $display("FAIL fwd_mode4_count: steps %0d up %0d, required 4 4",
                     step_cnt[0] - s_step[0], up_cnt[0] - s_up);
        end
        n_checks++;
        if (step_cnt[1] - s_step[1] != 2 || step_cnt[2] - s_step[2] != 1) begin
            n_fail++;
            $display("FAIL fwd_mode21_count: mode2 %0d mode1 %0d, required 2 1",
                     step_cnt[1] - s_step[1], step_cnt[2] - s_step[2]);
        end
    endtask

    task automatic test_backward;
        logic [1:0] seq [4];
        int s_step [3];
        int s_dn [3];
        int s_bad;
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        do_reset(1'b0, 1'b0);
        s_step = step_cnt;
        s_dn = dn_cnt;
        s_bad = bad_m1;
        for (int c = 0; c < 2; c++)
            for (int l = 0; l < 4; l++) drive(seq[l], 10);
        n_checks++;
        if (step_cnt[0] - s_step[0] != 8 || dn_cnt[0] - s_dn[0] != 8) begin
            n_fail++;
            $display("FAIL bwd_mode4: steps %0d down %0d, required 8 8",
                     step_cnt[0] - s_step[0], dn_cnt[0] - s_dn[0]);
        end
        n_checks++;
        if (step_cnt[1] - s_step[1] != 4 || dn_cnt[1] - s_dn[1] != 4) begin
            n_fail++;
            $display("FAIL bwd_mode2: steps %0d down %0d, required 4 4",
                     step_cnt[1] - s_step[1], dn_cnt[1] - s_dn[1]);
        end
        n_checks++;
        if (step_cnt[2] - s_step[2] != 2 || dn_cnt[2] - s_dn[2] != 2) begin
            n_fail++;
            $display("FAIL bwd_mode1: steps %0d down %0d, required 2 2",
                     step_cnt[2] - s_step[2], dn_cnt[2] - s_dn[2]);
        end
        n_checks++;
        if (bad_m1 - s_bad != 0) begin
            n_fail++;
            $display("FAIL bwd_mode1_entry: %0d steps outside 00, required 0", bad_m1 - s_bad);
        end
        n_checks++;
        if (dir[2] !== 1'b0 || dir[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bwd_dir_hold: mode2 %b mode1 %b, required 0 0", dir[1], dir[2]);
        end
    endtask

    task automatic test_glitch;
        int s_step [3];
        int s_up, s_dn;
        int s_err [3];
        s_step = step_cnt;
        s_err = err_seen;
        ch_a = 1'b1;
        tick(FC - 1);
        ch_a = 1'b0;
        tick(10);
        ch_b = 1'b1;
        tick(1);
        ch_b = 1'b0;
        tick(10);
        n_checks++;
        if (fab[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch_filtered: got %b, required 00", fab[0]);
        end
        n_checks++;
        if (step_cnt[0] - s_step[0] != 0 || err_seen[0] - s_err[0] != 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: steps %0d errors %0d, required 0 0",
                     step_cnt[0] - s_step[0], err_seen[0] - s_err[0]);
        end
        // A pulse of exactly FC cycles is the shortest that gets through.
        s_up = up_cnt[0];
        s_dn = dn_cnt[0];
        ch_a = 1'b1;
        tick(FC);
        ch_a = 1'b0;
        tick(15);
        n_checks++;
        if (up_cnt[0] - s_up != 1 || dn_cnt[0] - s_dn != 1 || err_seen[0] - s_err[0] != 0) begin
            n_fail++;
            $display("FAIL min_pulse: up %0d down %0d errors %0d, required 1 1 0",
                     up_cnt[0] - s_up, dn_cnt[0] - s_dn, err_seen[0] - s_err[0]);
        end
    endtask

    task automatic test_illegal;
        int s_step [3];
        int s_err [3];
        logic [1:0] ab;
        do_reset(1'b0, 1'b0);
        s_step = step_cnt;
        s_err = err_seen;
        ab = 2'b11;
        drive(ab, 10);
        n_checks++;
        if (err_seen[0] - s_err[0] != 1 || step_cnt[0] - s_step[0] != 0) begin
            n_fail++;
            $display("FAIL jump_pulse: errors %0d steps %0d, required 1 0",
                     err_seen[0] - s_err[0], step_cnt[0] - s_step[0]);
        end
        n_checks++;
        if (ecnt[0] !== 8'd1 || dir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_count: ecnt %0d dir %b, required 1 1", ecnt[0], dir[0]);
        end
        for (int j = 1; j < 300; j++) begin
            ab = ~ab;
            drive(ab, 8);
        end
        tick(4);
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (ecnt[m] !== 8'd255 || err_seen[m] - s_err[m] != 300) begin
                n_fail++;
                $display("FAIL err_saturate dut%0d: ecnt %0d pulses %0d, required 255 300",
                         m, ecnt[m], err_seen[m] - s_err[m]);
            end
        end
    endtask

    task automatic test_enable;
        int s_step [3];
        int s_up;
        int s_err;
        do_reset(1'b0, 1'b0);
        s_step = step_cnt;
        s_err = err_seen[0];
        en = 1'b0;
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        n_checks++;
        if (step_cnt[0] - s_step[0] != 0 || fab[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL disabled_track: steps %0d fab %b, required 0 01",
                     step_cnt[0] - s_step[0], fab[0]);
        end
        en = 1'b1;
        tick(5);
        s_step = step_cnt;
        s_up = up_cnt[0];
        drive(2'b00, 10);
        n_checks++;
        if (step_cnt[0] - s_step[0] != 1 || up_cnt[0] - s_up != 1 || step_cnt[2] - s_step[2] != 1) begin
            n_fail++;
            $display("FAIL reenable_step: mode4 %0d up %0d mode1 %0d, required 1 1 1",
                     step_cnt[0] - s_step[0], up_cnt[0] - s_up, step_cnt[2] - s_step[2]);
        end
        // Reset while a transition is still inside the filter.
        s_step = step_cnt;
        ch_a = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        n_checks++;
        if (rdy[0] !== 1'b0 || fab[0] !== 2'b00 || step[0] !== 1'b0 || dir[0] !== 1'b1 ||
            ecnt[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_state: rdy=%b fab=%b step=%b dir=%b ecnt=%0d, required 0 00 0 1 0",
                     rdy[0], fab[0], step[0], dir[0], ecnt[0]);
        end
        rst_n = 1'b1;
        tick(FC + 3);
        tick(10);
        n_checks++;
        if (rdy[0] !== 1'b1 || fab[0] !== 2'b10 || step_cnt[0] - s_step[0] != 0 ||
            err_seen[0] - s_err != 0) begin
            n_fail++;
            $display("FAIL midreset_reinit: rdy=%b fab=%b steps %0d errors %0d, required 1 10 0 0",
                     rdy[0], fab[0], step_cnt[0] - s_step[0], err_seen[0] - s_err);
        end
    endtask

    task automatic test_random;
        logic [1:0] tbl [4];
        int s_up [3];
        int s_dn [3];
        int s_err [3];
        int e_up [3];
        int e_dn [3];
        int pos, idx, fwd, last_fwd;
        tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
        do_reset(1'b0, 1'b0);
        s_up = up_cnt;
        s_dn = dn_cnt;
        s_err = err_seen;
        for (int m = 0; m < 3; m++) begin
            e_up[m] = 0;
            e_dn[m] = 0;
        end
        pos = 0;
        idx = 0;
        last_fwd = 1;
        for (int n = 0; n < 60; n++) begin
            fwd = int'($urandom_range(1, 0));
            pos = pos + (fwd != 0 ? 1 : -1);
            idx = ((pos % 4) + 4) % 4;
            // Mode 4 counts every step, mode 2 entries to 00/11, mode 1 entries to 00.
            for (int m = 0; m < 3; m++) begin
                if (m == 0 || (m == 1 && idx % 2 == 0) || (m == 2 && idx == 0)) begin
                    if (fwd != 0) e_up[m]++;
                    else e_dn[m]++;
                    if (m == 0) last_fwd = fwd;
                end
            end
            drive(tbl[idx], int'($urandom_range(14, 6)));
        end
        tick(10);
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (up_cnt[m] - s_up[m] != e_up[m] || dn_cnt[m] - s_dn[m] != e_dn[m] ||
                err_seen[m] - s_err[m] != 0) begin
                n_fail++;
                $display("FAIL random_counts dut%0d: up %0d down %0d err %0d, required %0d %0d 0",
                         m, up_cnt[m] - s_up[m], dn_cnt[m] - s_dn[m], err_seen[m] - s_err[m],
                         e_up[m], e_dn[m]);
            end
        end
        n_checks++;
        if (fab[0] !== tbl[idx] || dir[0] !== (last_fwd != 0)) begin
            n_fail++;
            $display("FAIL random_final: fab %b dir %b, required %b %b",
                     fab[0], dir[0], tbl[idx], last_fwd != 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_forward();
        test_backward();
        test_glitch();
        test_illegal();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
